ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, such as 8'hED (set LEDs) or 8'hFF (reset), and is the transmit counterpart of the PS/2 scan-code receiver. The block drives the open-drain PS2_clk and PS2_data pins through drive-low enables, checks the device's acknowledge bit, and reports completion or failure. While busy is high, the top level gates the receiver input so it does not decode the host's own frame.

---
 rtl/ps2_host_tx.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: runs the inhibit/request handshake, then shifts
// one command byte out on the device's clock and checks the device's acknowledge bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int REQ_CYCLES     = 100,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST     = CW'(REQ_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0] FILTER_LAST  = FW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;
    logic          fall_q, fall_d;
    logic [9:0]    frame_q, frame_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          clk_oe_q, clk_oe_d;
    logic          data_oe_q, data_oe_d;
    logic          busy_q, busy_d;
    logic          tx_ready_q, tx_ready_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    // The filtered clock only flips after FILTER_LEN consecutive samples disagree with it.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], PS2_clk};
        data_sync_d = {data_sync_q[0], PS2_data};
        filt_d      = filt_q;
        filt_cnt_d  = '0;
        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FILTER_LAST) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall_d = filt_q & ~filt_d;
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cnt_d     = cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_oe_d = data_oe_q;

        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    cnt_d     = '0;
                    to_cnt_d  = '0;
                    bit_cnt_d = '0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == REQ_LAST) begin
                    cnt_d    = '0;
                    to_cnt_d = '0;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall_q) begin
                    data_oe_d = ~frame_q[0];
                    frame_d   = {1'b1, frame_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (fall_q) begin
                    state_d = data_sync_q[1] ? S_FAIL : S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (filt_q && data_sync_q[1]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A device that stops clocking must not hang the host forever.
        if ((state_q == S_SEND || state_q == S_ACK || state_q == S_WAIT_IDLE) &&
            to_cnt_q == TIMEOUT_LAST) begin
            state_d = S_FAIL;
        end

        if (!(state_d == S_REQ || state_d == S_SEND || state_d == S_ACK ||
              state_d == S_WAIT_IDLE)) begin
            data_oe_d = 1'b0;
        end

        clk_oe_d   = (state_d == S_INHIBIT) || (state_d == S_REQ);
        busy_d     = (state_d != S_IDLE);
        tx_ready_d = (state_d == S_IDLE);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
            fall_q      <= 1'b0;
            frame_q     <= 10'h3FF;
            cnt_q       <= '0;
            to_cnt_q    <= '0;
            bit_cnt_q   <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            tx_ready_q  <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            filt_q      <= filt_d;
            filt_cnt_q  <= filt_cnt_d;
            fall_q      <= fall_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            to_cnt_q    <= to_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            tx_ready_q  <= tx_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign busy        = busy_q;
    assign tx_ready    = tx_ready_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model clocks frames out of the host
// and the captured bits, handshake timing and done/err pulses are compared to constants.
module tb_ps2_host_tx;

    localparam int INH  = 120;
    localparam int REQ  = 10;
    localparam int FILT = 8;
    localparam int TO   = 5000;
    localparam int HALF = 100;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_pin;
    logic       ps2_data_pin;
    logic       clk_oe;
    logic       data_oe;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    // Open-drain bus: either side pulling low wins.
    assign ps2_clk_pin  = dev_clk & ~clk_oe;
    assign ps2_data_pin = dev_data & ~data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .REQ_CYCLES    (REQ),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .PS2_clk    (ps2_clk_pin),
        .PS2_data   (ps2_data_pin),
        .ps2_clk_oe (clk_oe),
        .ps2_data_oe(data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Request a byte and follow the inhibit/request phase until the host releases the clock.
    task automatic applyStimulus(input logic [7:0] b);
        int hi;
        int dstart;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        checkOutput("clk_oe_after_accept", 32'(clk_oe), 32'd1);
        checkOutput("busy_after_accept", 32'(busy), 32'd1);
        checkOutput("tx_ready_after_accept", 32'(tx_ready), 32'd0);
        hi     = 1;
        dstart = 0;
        for (int k = 0; k < 1000 && clk_oe; k++) begin
            @(negedge clk);
            if (clk_oe) begin
                hi++;
                if (data_oe && dstart == 0) dstart = hi;
            end
        end
        checkOutput("clk_oe_width", hi, INH + REQ);
        checkOutput("data_oe_delay", dstart - 1, INH);
        checkOutput("start_bit_pin", 32'(ps2_data_pin), 32'd0);
    endtask

    // Device model: generates nclk clock pulses, samples data before each rising edge,
    // drives ack during the 11th low phase and optionally disturbs the transfer.
    task automatic deviceReceive(input int nclk, input logic ack, input bit disturb,
                                 output logic [9:0] bits);
        bits = '1;
        repeat (50) @(negedge clk);
        for (int i = 0; i < nclk; i++) begin
            dev_clk = 1'b0;
            if (i == 10) dev_data = ack;
            repeat (HALF) @(negedge clk);
            if (i < 10) begin
                bits[i] = ps2_data_pin;
                checkOutput("busy_in_send", 32'(busy), 32'd1);
            end
            dev_clk = 1'b1;
            if (i == 10) begin
                dev_data = 1'b1;
                break;
            end
            if (disturb && i == 2) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
                @(negedge clk);
                checkOutput("tx_ready_while_busy", 32'(tx_ready), 32'd0);
                tx_valid = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else if (disturb && i == 5) begin
                repeat (30) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (HALF - 33) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic waitDone(input string tag);
        int k;
        for (k = 0; k < 400 && !(done || err); k++) @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        checkOutput({tag, "_tx_ready_after"}, 32'(tx_ready), 32'd1);
        checkOutput({tag, "_busy_after"}, 32'(busy), 32'd0);
        checkOutput({tag, "_oe_after"}, {30'd0, clk_oe, data_oe}, 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        int base_d;
        int base_e;
        int k;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_clk_oe", 32'(clk_oe), 32'd0);
        checkOutput("rst_data_oe", 32'(data_oe), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_tx_ready", 32'(tx_ready), 32'd1);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] send 8'hED with ack");
        base_d = done_cnt;
        base_e = err_cnt;
        applyStimulus(8'hED);
        deviceReceive(11, 1'b0, 1'b0, bits);
        waitDone("ed");
        checkOutput("ed_bits", 32'(bits), 32'h3ED);
        checkOutput("ed_done_count", done_cnt - base_d, 1);
        checkOutput("ed_err_count", err_cnt - base_e, 0);

        $display("[TB] send 8'hF4 with ignored 8'hFF request and clock glitch");
        base_d = done_cnt;
        base_e = err_cnt;
        applyStimulus(8'hF4);
        deviceReceive(11, 1'b0, 1'b1, bits);
        waitDone("f4");
        checkOutput("f4_bits", 32'(bits), 32'h2F4);
        checkOutput("f4_done_count", done_cnt - base_d, 1);
        checkOutput("f4_err_count", err_cnt - base_e, 0);

        $display("[TB] send 8'h00 with nack");
        base_d = done_cnt;
        base_e = err_cnt;
        applyStimulus(8'h00);
        deviceReceive(11, 1'b1, 1'b0, bits);
        repeat (300) @(negedge clk);
        checkOutput("nack_bits", 32'(bits), 32'h300);
        checkOutput("nack_err_count", err_cnt - base_e, 1);
        checkOutput("nack_done_count", done_cnt - base_d, 0);
        checkOutput("nack_tx_ready", 32'(tx_ready), 32'd1);

        $display("[TB] device never clocks");
        base_d = done_cnt;
        applyStimulus(8'h5A);
        for (k = 0; k < TO + 1000 && !err; k++) @(negedge clk);
        checkOutput("timeout_cycles", k, TO);
        checkOutput("timeout_err", 32'(err), 32'd1);
        @(negedge clk);
        checkOutput("timeout_oe_after", {30'd0, clk_oe, data_oe}, 32'd0);
        checkOutput("timeout_tx_ready_after", 32'(tx_ready), 32'd1);
        checkOutput("timeout_err_one_cycle", 32'(err), 32'd0);
        checkOutput("timeout_no_done", done_cnt - base_d, 0);

        $display("[TB] reset during send");
        base_d = done_cnt;
        base_e = err_cnt;
        applyStimulus(8'hED);
        deviceReceive(5, 1'b0, 1'b0, bits);
        checkOutput("rst_mid_bits", 32'(bits[4:0]), 32'h0D);
        checkOutput("rst_mid_data_oe_before", 32'(data_oe), 32'd1);
        #1 rstn = 1'b0;
        #1;
        checkOutput("rst_mid_oe_async", {30'd0, clk_oe, data_oe}, 32'd0);
        checkOutput("rst_mid_busy_async", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("rst_mid_no_done", done_cnt - base_d, 0);
        checkOutput("rst_mid_no_err", err_cnt - base_e, 0);
        checkOutput("rst_mid_tx_ready", 32'(tx_ready), 32'd1);

        base_d = done_cnt;
        base_e = err_cnt;
        applyStimulus(8'hED);
        deviceReceive(11, 1'b0, 1'b0, bits);
        waitDone("ed2");
        checkOutput("ed2_bits", 32'(bits), 32'h3ED);
        checkOutput("ed2_done_count", done_cnt - base_d, 1);
        checkOutput("ed2_err_count", err_cnt - base_e, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
